instr_loader: RTL and testbench

Byte-stream loader that fills the core's instruction memory before execution starts. Accepts a length-prefixed, little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and issues one word-addressed write per word into the instruction RAM. It sits between the host link (UART/debug byte source) and the instruction memory write port, and holds the RV32I core in reset until the image is fully loaded.

---
 rtl/instr_loader_if.sv | 26 ++
 rtl/instr_loader.sv | 165 ++++++++++++++++
 tb/tb_instr_loader.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_loader_if : byte-stream handshake plus instruction-RAM write port
// Revision 1.0
// ----------------------------------------------------------------------------
interface instr_loader_if #(
    parameter int ADDR_W = 30
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    modport master (
        output s_valid, s_data,
        input  s_ready, we, waddr, wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, we, waddr, wdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_loader : length-prefixed LE byte stream -> instruction RAM writes,
// holds the core in reset until loaded. Optional: LOADER_CHECKSUM_EN.
// Revision 1.0
// ----------------------------------------------------------------------------
module instr_loader #(
    parameter int I_MEMSIZE = 100,
    parameter int ADDR_W    = 30
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    instr_loader_if.slave bus,
    output logic          core_rst_n,
    output logic          done,
    output logic          err
);
    localparam int          IDX_W     = $clog2(I_MEMSIZE + 1);
    localparam logic [31:0] MAX_WORDS = 32'(I_MEMSIZE);

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_LOAD = 3'd1,
        ST_LAST = 3'd2,
        ST_DONE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM = 3'd5,
`endif
        ST_ERR  = 3'd4
    } state_t;

    state_t            state_q;
    logic [31:0]       cnt_q;
    logic [23:0]       word_q;
    logic [1:0]        lane_q;
    logic [IDX_W-1:0]  widx_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              done_q;
    logic              err_q;
    logic              core_rst_n_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic        hs;
    logic        ready_d;
    logic [31:0] hdr_d;
    logic [31:0] word_d;

    // Bytes arrive LSB first, so shifting in from the top leaves them in place.
    assign hdr_d  = {bus.s_data, cnt_q[31:8]};
    assign word_d = {bus.s_data, word_q};
    assign hs     = bus.s_valid && ready_d;

    always_comb begin
        ready_d = 1'b0;
        case (state_q)
            ST_HDR, ST_LOAD: ready_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM:         ready_d = 1'b1;
`endif
            default:         ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_HDR;
            cnt_q        <= '0;
            word_q       <= '0;
            lane_q       <= '0;
            widx_q       <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            we_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            if (hs && state_q != ST_CSUM)
                csum_q <= csum_q ^ bus.s_data;
`endif
            case (state_q)
                ST_HDR: begin
                    if (hs) begin
                        cnt_q  <= hdr_d;
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            if (hdr_d == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                state_q      <= ST_CSUM;
`else
                                state_q      <= ST_DONE;
                                done_q       <= 1'b1;
                                core_rst_n_q <= 1'b1;
`endif
                            end else if (hdr_d > MAX_WORDS) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end else begin
                                state_q <= ST_LOAD;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        word_q <= {bus.s_data, word_q[23:8]};
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            we_q    <= 1'b1;
                            waddr_q <= ADDR_W'(widx_q);
                            wdata_q <= word_d;
                            widx_q  <= widx_q + 1'b1;
                            if (32'(widx_q) == cnt_q - 32'd1)
                                state_q <= ST_LAST;
                        end
                    end
                end
                ST_LAST: begin
`ifdef LOADER_CHECKSUM_EN
                    state_q      <= ST_CSUM;
`else
                    state_q      <= ST_DONE;
                    done_q       <= 1'b1;
                    core_rst_n_q <= 1'b1;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (hs) begin
                        if (bus.s_data == csum_q) begin
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            core_rst_n_q <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: state_q <= ST_DONE;
                ST_ERR:  state_q <= ST_ERR;
                default: state_q <= ST_ERR;
            endcase
        end
    end

    assign bus.s_ready = ready_d;
    assign bus.we      = we_q;
    assign bus.waddr   = waddr_q;
    assign bus.wdata   = wdata_q;
    assign core_rst_n  = core_rst_n_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instr_loader : randomized image loads against a byte-list reference model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_instr_loader;
    localparam int C_MEMSIZE = 100;
    localparam int C_ADDR_W  = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic core_rst_n, done, err;

    instr_loader_if #(.ADDR_W(C_ADDR_W)) bus ();

    instr_loader #(.I_MEMSIZE(C_MEMSIZE), .ADDR_W(C_ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .core_rst_n(core_rst_n),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cyc = -1;
    int rstbad   = 0;

    int            hs_cyc[$];
    int            we_cyc[$];
    logic [29:0]   we_addr[$];
    logic [31:0]   we_data[$];
    logic [7:0]    img_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe mid-cycle: a handshake seen in cycle c lands on the edge ending c.
    always @(negedge clk) begin
        if (bus.s_valid && bus.s_ready) hs_cyc.push_back(cyc);
        if (bus.we === 1'b1) begin
            we_cyc.push_back(cyc);
            we_addr.push_back(bus.waddr);
            we_data.push_back(bus.wdata);
        end
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (core_rst_n !== done) rstbad++;
    end

    task automatic clear_obs();
        hs_cyc.delete(); we_cyc.delete(); we_addr.delete(); we_data.delete();
        done_cyc = -1;
        rstbad   = 0;
    endtask

    task automatic do_reset();
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        bus.s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL send_byte: s_ready got 0 required 1 within 50 cycles");
        end
    endtask

    task automatic build_image(input int n);
        img_q.delete();
        for (int i = 0; i < 4; i++) img_q.push_back(8'((n >> (8 * i)) & 255));
        for (int i = 0; i < 4 * n; i++) img_q.push_back(8'($urandom_range(255, 0)));
    endtask

    task automatic build_n2();
        img_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00};
    endtask

    // Stream img_q (plus checksum when enabled) and compare against the byte list.
    task automatic run_image(input string tname, input int maxgap, input bit rst_first);
        logic [7:0]  bytes[$];
        logic [7:0]  x;
        logic [31:0] n, exp_w;
        int          last_i, exp_done, lim;
        if (rst_first) do_reset();
        clear_obs();
        bytes = img_q;
        x = 8'h00;
        foreach (img_q[i]) x = x ^ img_q[i];
`ifdef LOADER_CHECKSUM_EN
        bytes.push_back(x);
`endif
        foreach (bytes[i]) send_byte(bytes[i], $urandom_range(maxgap, 0));
        repeat (3) begin @(posedge clk); #1; end
        n = {img_q[3], img_q[2], img_q[1], img_q[0]};

        n_checks++;
        if (hs_cyc.size() !== bytes.size()) begin
            n_fail++;
            $display("FAIL %s handshakes: got %0d required %0d", tname, hs_cyc.size(), bytes.size());
        end
        n_checks++;
        if (we_cyc.size() !== int'(n)) begin
            n_fail++;
            $display("FAIL %s we_count: got %0d required %0d", tname, we_cyc.size(), n);
        end
        lim = (we_cyc.size() < int'(n)) ? we_cyc.size() : int'(n);
        for (int k = 0; k < lim; k++) begin
            exp_w = {img_q[4*k+7], img_q[4*k+6], img_q[4*k+5], img_q[4*k+4]};
            n_checks++;
            if (we_addr[k] !== 30'(k)) begin
                n_fail++;
                $display("FAIL %s waddr[%0d]: got %0d required %0d", tname, k, we_addr[k], k);
            end
            n_checks++;
            if (we_data[k] !== exp_w) begin
                n_fail++;
                $display("FAIL %s wdata[%0d]: got %h required %h", tname, k, we_data[k], exp_w);
            end
            if (hs_cyc.size() > 4*k+7) begin
                n_checks++;
                if (we_cyc[k] !== hs_cyc[4*k+7] + 1) begin
                    n_fail++;
                    $display("FAIL %s we_latency[%0d]: got cycle %0d required %0d",
                             tname, k, we_cyc[k], hs_cyc[4*k+7] + 1);
                end
            end
        end
        last_i = bytes.size() - 1;
        if (hs_cyc.size() > last_i) begin
`ifdef LOADER_CHECKSUM_EN
            exp_done = hs_cyc[last_i] + 1;
`else
            exp_done = (n == 0) ? hs_cyc[last_i] + 1 : hs_cyc[last_i] + 2;
`endif
            n_checks++;
            if (done_cyc !== exp_done) begin
                n_fail++;
                $display("FAIL %s done_cycle: got %0d required %0d", tname, done_cyc, exp_done);
            end
        end
        n_checks++;
        if ({done, core_rst_n, err, bus.s_ready} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s final done/core_rst_n/err/s_ready: got %b required 1100",
                     tname, {done, core_rst_n, err, bus.s_ready});
        end
        n_checks++;
        if (rstbad !== 0) begin
            n_fail++;
            $display("FAIL %s core_rst_n_vs_done: got %0d bad cycles required 0", tname, rstbad);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.s_ready, bus.we, core_rst_n, done, err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset flags s_ready/we/core_rst_n/done/err: got %b required 10000",
                     {bus.s_ready, bus.we, core_rst_n, done, err});
        end
        n_checks++;
        if (bus.waddr !== 30'd0 || bus.wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset waddr/wdata: got %h/%h required 0/0", bus.waddr, bus.wdata);
        end
    endtask

    task automatic test_load_n2();
        build_n2();
        run_image("load_n2", 0, 1'b1);
    endtask

    task automatic test_zero();
        build_image(0);
        run_image("zero", 0, 1'b1);
    endtask

    task automatic test_gapped();
        build_n2();
        run_image("gapped", 5, 1'b1);
        build_image($urandom_range(6, 1));
        run_image("gapped_rand", 5, 1'b1);
    endtask

    task automatic test_back_to_back();
        build_image(1);
        run_image("single_word", 0, 1'b1);
        build_image($urandom_range(12, 2));
        run_image("back_to_back", 0, 1'b1);
        build_image(C_MEMSIZE);
        run_image("max_words", 0, 1'b1);
    endtask

    task automatic test_overflow(input string tname, input logic [31:0] n);
        do_reset();
        clear_obs();
        for (int i = 0; i < 4; i++) send_byte(8'(n >> (8 * i)), 0);
        n_checks++;
        if ({err, bus.s_ready, core_rst_n, done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s err/s_ready/core_rst_n/done: got %b required 1000",
                     tname, {err, bus.s_ready, core_rst_n, done});
        end
        bus.s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.s_data = 8'($urandom_range(255, 0));
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (we_cyc.size() !== 0 || hs_cyc.size() !== 4) begin
            n_fail++;
            $display("FAIL %s writes/handshakes: got %0d/%0d required 0/4",
                     tname, we_cyc.size(), hs_cyc.size());
        end
        n_checks++;
        if (err !== 1'b1 || core_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL %s sticky err/core_rst_n: got %b%b required 10", tname, err, core_rst_n);
        end
    endtask

    task automatic test_reset_mid();
        build_n2();
        do_reset();
        clear_obs();
        for (int i = 0; i < 6; i++) send_byte(img_q[i], 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (we_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_mid we_count: got %0d required 0", we_cyc.size());
        end
        n_checks++;
        if ({bus.s_ready, done, err} !== 3'b100 || bus.waddr !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_mid state s_ready/done/err=%b waddr=%0d required 100/0",
                     {bus.s_ready, done, err}, bus.waddr);
        end
        run_image("reload", 2, 1'b0);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        logic [7:0] x;
        build_n2();
        do_reset();
        clear_obs();
        x = 8'h00;
        foreach (img_q[i]) begin
            x = x ^ img_q[i];
            send_byte(img_q[i], 0);
        end
        send_byte(x ^ 8'h01, 0);
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if ({err, core_rst_n, done, bus.s_ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL bad_csum err/core_rst_n/done/s_ready: got %b required 1000",
                     {err, core_rst_n, done, bus.s_ready});
        end
        n_checks++;
        if (we_cyc.size() !== 2) begin
            n_fail++;
            $display("FAIL bad_csum we_count: got %0d required 2", we_cyc.size());
        end
    endtask
`endif

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        test_reset();
        test_load_n2();
        test_zero();
        test_overflow("overflow_101", 32'd101);
        test_overflow("overflow_hi", 32'h0100_0005);
        test_gapped();
        test_back_to_back();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
